dmem_bridge: RTL and testbench

- Data-side bridge between the single-cycle MIPS core's load/store port and an external handshaked data memory.
- Stores are posted into a WB_DEPTH-entry write buffer so the core does not wait on them.
- Loads drain the buffer, issue a read, and hold the core on `stall` until data returns.
- Sits directly downstream of the core: consumes `memwrite`/`aluout`/`writedata` and produces `readdata`.

---
 rtl/dmem_bridge_if.sv | 34 +++
 rtl/dmem_bridge.sv | 167 ++++++++++++++++
 tb/tb_dmem_bridge.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_bridge_if.sv
// Core load/store port and external data-memory handshake of dmem_bridge.
// slave is the bridge's view; master is the core-plus-memory environment's view.
interface dmem_bridge_if;
  logic        memwrite;
  logic        memread;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [3:0]  be;
  logic [31:0] readdata;
  logic        stall;
  logic        wb_empty;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport slave (
    input  memwrite, memread, aluout, writedata, be,
    input  mem_ready, mem_rvalid, mem_rdata,
    output readdata, stall, wb_empty,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output memwrite, memread, aluout, writedata, be,
    output mem_ready, mem_rvalid, mem_rdata,
    input  readdata, stall, wb_empty,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/dmem_bridge.sv
// Data-side bridge: posted write buffer plus blocking load FSM toward a handshaked memory.
// Define DMEM_BRIDGE_FWD_EN to forward full-word buffered stores to loads in IDLE.
module dmem_bridge #(
  parameter int WB_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  dmem_bridge_if.slave  bus
);
  localparam int AW = $clog2(WB_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] DRAIN   = 3'd1;
  localparam logic [2:0] RD_REQ  = 3'd2;
  localparam logic [2:0] RD_WAIT = 3'd3;
  localparam logic [2:0] RD_DONE = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [29:0]   wb_addr_q [WB_DEPTH];
  logic [31:0]   wb_data_q [WB_DEPTH];
  logic [3:0]    wb_be_q   [WB_DEPTH];

  logic          full, empty, push, pop, drain_act;
  logic          fwd_hit;
  logic [31:0]   fwd_data;
  logic          unused_lsb;

  assign unused_lsb = ^bus.aluout[1:0];

  assign full      = (cnt_q == CW'(WB_DEPTH));
  assign empty     = (cnt_q == '0);
  // A pop in the same cycle never frees the slot for a push; full uses the registered count.
  assign push      = bus.memwrite && !full;
  assign drain_act = !empty && ((state_q == IDLE) || (state_q == DRAIN));
  assign pop       = drain_act && bus.mem_ready;

`ifdef DMEM_BRIDGE_FWD_EN
  logic          fwd_match;
  logic [3:0]    fwd_be;
  logic [AW-1:0] fwd_idx;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    fwd_match = 1'b0;
    fwd_be    = 4'h0;
    fwd_data  = 32'h0;
    fwd_idx   = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      fwd_idx = rd_ptr_q + AW'(i);
      if ((CW'(i) < cnt_q) && (wb_addr_q[fwd_idx] == bus.aluout[31:2])) begin
        fwd_match = 1'b1;
        fwd_be    = wb_be_q[fwd_idx];
        fwd_data  = wb_data_q[fwd_idx];
      end
    end
    fwd_hit = (state_q == IDLE) && bus.memread && fwd_match && (fwd_be == 4'hF);
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = 32'h0;
`endif

  always_comb begin
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.memread && !fwd_hit) state_d = empty ? RD_REQ : DRAIN;
      end
      DRAIN: begin
        if (empty) state_d = RD_REQ;
      end
      RD_REQ: begin
        if (bus.mem_ready && bus.mem_rvalid) begin
          rdata_d = bus.mem_rdata;
          state_d = RD_DONE;
        end else if (bus.mem_ready) begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (bus.mem_rvalid) begin
          rdata_d = bus.mem_rdata;
          state_d = RD_DONE;
        end
      end
      RD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.stall = 1'b0;
    case (state_q)
      IDLE:                  bus.stall = bus.memread && !fwd_hit;
      DRAIN, RD_REQ, RD_WAIT: bus.stall = 1'b1;
      default:               bus.stall = 1'b0;
    endcase
    if (bus.memwrite && full) bus.stall = 1'b1;
  end

  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    bus.mem_be    = 4'h0;
    if (drain_act) begin
      bus.mem_req   = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_addr  = {wb_addr_q[rd_ptr_q], 2'b00};
      bus.mem_wdata = wb_data_q[rd_ptr_q];
      bus.mem_be    = wb_be_q[rd_ptr_q];
    end else if (state_q == RD_REQ) begin
      bus.mem_req  = 1'b1;
      bus.mem_addr = {bus.aluout[31:2], 2'b00};
    end
  end

  assign bus.readdata = fwd_hit ? fwd_data : rdata_q;
  assign bus.wb_empty = empty;

  // Control state and the load-data register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rdata_q  <= rdata_d;
    end
  end

  // Buffer storage: validity comes from the pointers, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      wb_addr_q[wr_ptr_q] <= bus.aluout[31:2];
      wb_data_q[wr_ptr_q] <= bus.writedata;
      wb_be_q[wr_ptr_q]   <= bus.be;
    end
  end
endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge; inputs change 1ns after the rising edge, outputs checked 1ns later.
module tb_dmem_bridge;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  dmem_bridge_if bus();

  dmem_bridge #(.WB_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.memwrite   = 1'b0;
    bus.memread    = 1'b0;
    bus.aluout     = 32'h0;
    bus.writedata  = 32'h0;
    bus.be         = 4'h0;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    #1;
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0h exp=0", bus.stall); end
    checks++; if (bus.wb_empty !== 1'b1) begin failures++; $display("FAIL rst_wb_empty got=%0h exp=1", bus.wb_empty); end
    checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%0h exp=0", bus.mem_req); end
    checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%0h exp=0", bus.mem_we); end
    checks++; if (bus.mem_addr !== 32'h0) begin failures++; $display("FAIL rst_mem_addr got=%0h exp=0", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_mem_wdata got=%0h exp=0", bus.mem_wdata); end
    checks++; if (bus.mem_be !== 4'h0) begin failures++; $display("FAIL rst_mem_be got=%0h exp=0", bus.mem_be); end
    checks++; if (bus.readdata !== 32'h0) begin failures++; $display("FAIL rst_readdata got=%0h exp=0", bus.readdata); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] addrs [3];
    addrs[0] = 32'h10; addrs[1] = 32'h14; addrs[2] = 32'h18;
    bus.mem_ready = 1'b1;
    bus.memwrite  = 1'b1;
    bus.be        = 4'hF;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        bus.aluout    = addrs[k];
        bus.writedata = 32'(k + 1);
      end else begin
        bus.memwrite = 1'b0;
      end
      #1;
      checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL b2b_stall k=%0d got=%0h exp=0", k, bus.stall); end
      if (k == 0) begin
        checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL b2b_req0 got=%0h exp=0", bus.mem_req); end
      end else begin
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin failures++; $display("FAIL b2b_req k=%0d got=%0h/%0h exp=1/1", k, bus.mem_req, bus.mem_we); end
        checks++; if (bus.mem_addr !== addrs[k-1]) begin failures++; $display("FAIL b2b_addr k=%0d got=%0h exp=%0h", k, bus.mem_addr, addrs[k-1]); end
        checks++; if (bus.mem_wdata !== 32'(k)) begin failures++; $display("FAIL b2b_wdata k=%0d got=%0h exp=%0h", k, bus.mem_wdata, k); end
      end
      tick();
    end
    checks++; if (bus.wb_empty !== 1'b1) begin failures++; $display("FAIL b2b_wb_empty got=%0h exp=1", bus.wb_empty); end
    idle_inputs();
  endtask

  task automatic test_full;
    bus.mem_ready = 1'b0;
    bus.memwrite  = 1'b1;
    bus.be        = 4'hF;
    for (int k = 0; k < 4; k++) begin
      bus.aluout    = 32'h40 + 32'(4 * k);
      bus.writedata = 32'hA0 + 32'(k);
      #1;
      checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL full_accept k=%0d stall got=%0h exp=0", k, bus.stall); end
      tick();
    end
    bus.aluout    = 32'h50;
    bus.writedata = 32'hA4;
    #1;
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL full_stall got=%0h exp=1", bus.stall); end
    checks++; if (bus.mem_addr !== 32'h40) begin failures++; $display("FAIL full_head got=%0h exp=40", bus.mem_addr); end
    tick();
    bus.mem_ready = 1'b1;
    #1;
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL full_stall_pop got=%0h exp=1", bus.stall); end
    tick();
    bus.mem_ready = 1'b0;
    #1;
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL full_push_next got=%0h exp=0", bus.stall); end
    checks++; if (bus.mem_addr !== 32'h44) begin failures++; $display("FAIL full_head2 got=%0h exp=44", bus.mem_addr); end
    tick();
    bus.memwrite  = 1'b0;
    bus.mem_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      #1;
      checks++; if (bus.mem_addr !== 32'h40 + 32'(4 * k) || bus.mem_wdata !== 32'hA0 + 32'(k)) begin failures++; $display("FAIL full_drain k=%0d got=%0h/%0h exp=%0h/%0h", k, bus.mem_addr, bus.mem_wdata, 32'h40 + 32'(4 * k), 32'hA0 + 32'(k)); end
      tick();
    end
    checks++; if (bus.wb_empty !== 1'b1) begin failures++; $display("FAIL full_wb_empty got=%0h exp=1", bus.wb_empty); end
    idle_inputs();
  endtask

  task automatic test_load;
    bus.memread = 1'b1;
    bus.aluout  = 32'h100;
    #1;
    checks++; if (bus.stall !== 1'b1 || bus.mem_req !== 1'b0) begin failures++; $display("FAIL ld_idle stall/req got=%0h/%0h exp=1/0", bus.stall, bus.mem_req); end
    tick();
    bus.mem_ready = 1'b1;
    #1;
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL ld_req_stall got=%0h exp=1", bus.stall); end
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_be !== 4'h0) begin failures++; $display("FAIL ld_req req/we/be got=%0h/%0h/%0h exp=1/0/0", bus.mem_req, bus.mem_we, bus.mem_be); end
    checks++; if (bus.mem_addr !== 32'h100) begin failures++; $display("FAIL ld_req_addr got=%0h exp=100", bus.mem_addr); end
    tick();
    bus.mem_ready = 1'b0;
    #1;
    checks++; if (bus.stall !== 1'b1 || bus.mem_req !== 1'b0) begin failures++; $display("FAIL ld_wait stall/req got=%0h/%0h exp=1/0", bus.stall, bus.mem_req); end
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEADBEEF;
    #1;
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL ld_rvalid_stall got=%0h exp=1", bus.stall); end
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    #1;
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL ld_done_stall got=%0h exp=0", bus.stall); end
    checks++; if (bus.readdata !== 32'hDEADBEEF) begin failures++; $display("FAIL ld_done_data got=%0h exp=deadbeef", bus.readdata); end
    tick();
    bus.memread = 1'b0;
    #1;
    checks++; if (bus.readdata !== 32'hDEADBEEF) begin failures++; $display("FAIL ld_hold_data got=%0h exp=deadbeef", bus.readdata); end
    idle_inputs();
  endtask

  task automatic test_zero_wait;
    bus.memread = 1'b1;
    bus.aluout  = 32'h104;
    #1;
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL zw_idle_stall got=%0h exp=1", bus.stall); end
    tick();
    bus.mem_ready  = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h55AA1234;
    #1;
    checks++; if (bus.stall !== 1'b1 || bus.mem_req !== 1'b1) begin failures++; $display("FAIL zw_req stall/req got=%0h/%0h exp=1/1", bus.stall, bus.mem_req); end
    tick();
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    #1;
    checks++; if (bus.stall !== 1'b0 || bus.readdata !== 32'h55AA1234) begin failures++; $display("FAIL zw_done stall/data got=%0h/%0h exp=0/55aa1234", bus.stall, bus.readdata); end
    tick();
    idle_inputs();
  endtask

  task automatic test_store_load;
    bus.memwrite  = 1'b1;
    bus.aluout    = 32'h200;
    bus.writedata = 32'hCAFEF00D;
    bus.be        = 4'hF;
    tick();
    bus.memwrite = 1'b0;
    bus.memread  = 1'b1;
    #1;
`ifdef DMEM_BRIDGE_FWD_EN
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL fwd_stall got=%0h exp=0", bus.stall); end
    checks++; if (bus.readdata !== 32'hCAFEF00D) begin failures++; $display("FAIL fwd_data got=%0h exp=cafef00d", bus.readdata); end
    checks++; if (bus.mem_req === 1'b1 && bus.mem_we !== 1'b1) begin failures++; $display("FAIL fwd_no_read we got=%0h exp=1", bus.mem_we); end
    tick();
    bus.memread   = 1'b0;
    bus.mem_ready = 1'b1;
    tick();
    checks++; if (bus.wb_empty !== 1'b1) begin failures++; $display("FAIL fwd_drained got=%0h exp=1", bus.wb_empty); end
`else
    checks++; if (bus.stall !== 1'b1 || bus.mem_we !== 1'b1) begin failures++; $display("FAIL sl_idle stall/we got=%0h/%0h exp=1/1", bus.stall, bus.mem_we); end
    tick();
    bus.mem_ready = 1'b1;
    #1;
    checks++; if (bus.stall !== 1'b1 || bus.mem_addr !== 32'h200 || bus.mem_we !== 1'b1) begin failures++; $display("FAIL sl_drain stall/addr/we got=%0h/%0h/%0h exp=1/200/1", bus.stall, bus.mem_addr, bus.mem_we); end
    tick();
    bus.mem_ready = 1'b0;
    #1;
    checks++; if (bus.stall !== 1'b1 || bus.mem_req !== 1'b0) begin failures++; $display("FAIL sl_drain_end stall/req got=%0h/%0h exp=1/0", bus.stall, bus.mem_req); end
    tick();
    bus.mem_ready  = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFEF00D;
    #1;
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h200) begin failures++; $display("FAIL sl_rdreq req/we/addr got=%0h/%0h/%0h exp=1/0/200", bus.mem_req, bus.mem_we, bus.mem_addr); end
    tick();
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    #1;
    checks++; if (bus.stall !== 1'b0 || bus.readdata !== 32'hCAFEF00D) begin failures++; $display("FAIL sl_done stall/data got=%0h/%0h exp=0/cafef00d", bus.stall, bus.readdata); end
    tick();
`endif
    idle_inputs();
  endtask

  task automatic test_partial;
    bus.memwrite  = 1'b1;
    bus.aluout    = 32'h300;
    bus.writedata = 32'h11;
    bus.be        = 4'h1;
    tick();
    bus.memwrite = 1'b0;
    bus.memread  = 1'b1;
    #1;
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL part_no_fwd stall got=%0h exp=1", bus.stall); end
    tick();
    bus.mem_ready = 1'b1;
    #1;
    checks++; if (bus.stall !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_be !== 4'h1) begin failures++; $display("FAIL part_drain stall/we/be got=%0h/%0h/%0h exp=1/1/1", bus.stall, bus.mem_we, bus.mem_be); end
    tick();
    bus.mem_ready = 1'b0;
    tick();
    bus.mem_ready  = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h11;
    #1;
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h300) begin failures++; $display("FAIL part_rdreq req/we/addr got=%0h/%0h/%0h exp=1/0/300", bus.mem_req, bus.mem_we, bus.mem_addr); end
    tick();
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_midop;
    bus.memread = 1'b1;
    bus.aluout  = 32'h400;
    tick();
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset          = 1'b0;
    bus.memread    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h12345678;
    tick();
    bus.mem_rvalid = 1'b0;
    #1;
    checks++; if (bus.readdata !== 32'h0) begin failures++; $display("FAIL rmid_readdata got=%0h exp=0", bus.readdata); end
    checks++; if (bus.mem_req !== 1'b0 || bus.stall !== 1'b0) begin failures++; $display("FAIL rmid_req_stall got=%0h/%0h exp=0/0", bus.mem_req, bus.stall); end
    checks++; if (bus.wb_empty !== 1'b1) begin failures++; $display("FAIL rmid_wb_empty got=%0h exp=1", bus.wb_empty); end
    tick();
    bus.memread = 1'b1;
    bus.aluout  = 32'h404;
    #1;
    checks++; if (bus.stall !== 1'b1 || bus.mem_req !== 1'b0) begin failures++; $display("FAIL rmid_idle stall/req got=%0h/%0h exp=1/0", bus.stall, bus.mem_req); end
    tick();
    #1;
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h404) begin failures++; $display("FAIL rmid_rdreq req/addr got=%0h/%0h exp=1/404", bus.mem_req, bus.mem_addr); end
    bus.mem_ready  = 1'b1;
    bus.mem_rvalid = 1'b1;
    tick();
    idle_inputs();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_back_to_back();
    test_full();
    test_load();
    test_zero_wait();
    test_store_load();
    test_partial();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
